// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// The result-select helper maps each funct3 to the low or high accumulator half.
package muldiv_pkg;

  localparam int XLEN       = 32;
  localparam int ITER_COUNT = 32;

  localparam logic [4:0]      LAST_ITER = 5'(ITER_COUNT - 1);
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // MUL and DIV/DIVU take the low half (product low / quotient); everything else the high half.
  function automatic logic [XLEN-1:0] select_result(input logic [2:0] op,
                                                    input logic [2*XLEN-1:0] acc);
    if (op == OP_MUL || op[2:1] == 2'b10)
      return acc[XLEN-1:0];
    else
      return acc[2*XLEN-1:XLEN];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand magnitudes at accept time and the
// final negation of product / quotient / remainder in the FIX state.
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [XLEN-1:0]   a_mag,
  output logic [XLEN-1:0]   b_mag,
  output logic              neg_main,
  output logic              neg_rem,
  input  logic              fix_div,
  input  logic              fix_neg_main,
  input  logic              fix_neg_rem,
  input  logic [2*XLEN-1:0] fix_in,
  output logic [2*XLEN-1:0] fix_out
);

  logic a_signed;
  logic b_signed;
  logic a_neg;
  logic b_neg;
  logic [XLEN-1:0] fix_hi;
  logic [XLEN-1:0] fix_lo;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = a_signed & op_a[XLEN-1];
  assign b_neg = b_signed & op_b[XLEN-1];

  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  // For divides neg_main flips the quotient; the remainder follows the dividend.
  assign neg_main = a_neg ^ b_neg;
  assign neg_rem  = a_neg & funct3[2];

  assign fix_hi = fix_in[2*XLEN-1:XLEN];
  assign fix_lo = fix_in[XLEN-1:0];

  always_comb begin
    fix_out = fix_in;
    if (fix_div)
      fix_out = {(fix_neg_rem ? -fix_hi : fix_hi), (fix_neg_main ? -fix_lo : fix_lo)};
    else if (fix_neg_main)
      fix_out = -fix_in;
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring
// shift-subtract steps over one shared 64-bit accumulator, then a sign fix.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  state_t              state_reg;
  logic [4:0]          count_reg;
  logic [2:0]          op_reg;
  logic [XLEN-1:0]     opnd_reg;
  logic [2*XLEN-1:0]   acc_reg;
  logic                neg_main_reg;
  logic                neg_rem_reg;

  logic [XLEN-1:0]     a_mag;
  logic [XLEN-1:0]     b_mag;
  logic                neg_main;
  logic                neg_rem;
  logic [2*XLEN-1:0]   fixed;

  muldiv_sign_fix u_sign_fix (
    .funct3       (funct3),
    .op_a         (op_a),
    .op_b         (op_b),
    .a_mag        (a_mag),
    .b_mag        (b_mag),
    .neg_main     (neg_main),
    .neg_rem      (neg_rem),
    .fix_div      (op_reg[2]),
    .fix_neg_main (neg_main_reg),
    .fix_neg_rem  (neg_rem_reg),
    .fix_in       (acc_reg),
    .fix_out      (fixed)
  );

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_result;

  assign div_zero = funct3[2] && (op_b == '0);
  assign div_ovf  = funct3[2] && !funct3[0] && (op_a == INT_MIN) && (op_b == '1);
  assign special  = div_zero | div_ovf;

  always_comb begin
    special_result = '0;
    if (div_zero)
      special_result = funct3[1] ? op_a : '1;
    else if (!funct3[1])
      special_result = INT_MIN;
  end

  // Multiply: multiplier sits in the low half and shifts out LSB-first.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[XLEN-1:1]};

  // Divide: remainder:quotient shifts left, quotient bit enters at the LSB.
  logic [2*XLEN:0]   div_sh;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;

  assign div_sh   = {acc_reg, 1'b0};
  assign div_diff = {1'b0, div_sh[2*XLEN:XLEN]} - {2'b00, opnd_reg};
  assign div_next = div_diff[XLEN+1] ? div_sh[2*XLEN-1:0]
                                     : {div_diff[XLEN-1:0], div_sh[XLEN-1:1], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      count_reg    <= '0;
      op_reg       <= '0;
      opnd_reg     <= '0;
      acc_reg      <= '0;
      neg_main_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !flush) begin
            op_reg       <= funct3;
            opnd_reg     <= b_mag;
            acc_reg      <= {{XLEN{1'b0}}, a_mag};
            neg_main_reg <= neg_main;
            neg_rem_reg  <= neg_rem;
            count_reg    <= '0;
            busy         <= 1'b1;
            if (special) begin
              result    <= special_result;
              done      <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              state_reg <= S_ITER;
            end
          end
        end
        S_ITER: begin
          if (flush) begin
            state_reg <= S_IDLE;
            busy      <= 1'b0;
          end else begin
            acc_reg   <= op_reg[2] ? div_next : mul_next;
            count_reg <= count_reg + 5'd1;
            if (count_reg == LAST_ITER)
              state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush) begin
            state_reg <= S_IDLE;
            busy      <= 1'b0;
          end else begin
            acc_reg   <= fixed;
            result    <= select_result(op_reg, fixed);
            done      <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  assign stall = start & ~done;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vectors, randomized ops
// against an arithmetic reference, back-to-back, flush and mid-op reset.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        stall;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_exp = 32'h0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result),
    .stall  (stall)
  );

  // Reference built from RV32M arithmetic rules using wide multiplies and native division.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0]        xa;
    logic [63:0]        xb;
    logic [63:0]        p;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    logic [31:0]        r;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    xa  = {((f != 3'd3 && a[31]) ? 32'hFFFFFFFF : 32'h0), a};
    xb  = {(((f == 3'd0 || f == 3'd1) && b[31]) ? 32'hFFFFFFFF : 32'h0), b};
    p   = xa * xb;
    case (f)
      3'd0:    r = p[31:0];
      3'd1, 3'd2, 3'd3: r = p[63:32];
      3'd4:    r = (b == 0) ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'(sa / sb);
      3'd5:    r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6:    r = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
      return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns one negedge after done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input bit keep);
    int lat;
    bit seen;
    int bad_hold;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    flush  = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL accept_idle: stall=%b busy=%b required stall=1 busy=0", stall, busy);
    end
    @(posedge clk);
    #1;
    funct3 = 3'($urandom);
    op_a   = $urandom;
    op_b   = $urandom;
    lat = 0;
    seen = 0;
    bad_hold = 0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) seen = 1;
      else if (stall !== 1'b1 || busy !== 1'b1) bad_hold++;
    end
    checks++;
    if (bad_hold != 0) begin
      errors++;
      $display("FAIL hold_stall: %0d cycles with stall/busy low before done, required 0", bad_hold);
    end
    checks++;
    if (!seen || lat != exp_lat) begin
      errors++;
      $display("FAIL latency: f=%0d a=%h b=%h done_seen=%0d lat=%0d required %0d",
               f, a, b, seen, lat, exp_lat);
    end
    checks++;
    if (result !== exp || stall !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL result: f=%0d a=%h b=%h got %h stall=%b busy=%b required %h stall=0 busy=1",
               f, a, b, result, stall, busy, exp);
    end
    $display("OP f=%0d a=%h b=%h result=%h lat=%0d", f, a, b, result, lat);
    last_exp = exp;
    if (!keep) start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b result=%h required 0 0 %h", done, busy, result, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b result=%h stall=%b required all zero",
               busy, done, result, stall);
    end
    rst_n = 1'b1;
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b0);
  endtask

  task automatic test_directed();
    logic [2:0]  tf   [8] = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd6, 3'd4, 3'd7};
    logic [31:0] ta   [8] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                              32'd5, 32'd5, 32'h80000000, 32'd9};
    logic [31:0] tb   [8] = '{32'h80000000, 32'hFFFFFFFF, 32'd2, 32'd2,
                              32'd0, 32'd0, 32'hFFFFFFFF, 32'd0};
    logic [31:0] texp [8] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd9};
    int          tlat [8] = '{34, 34, 34, 34, 1, 1, 1, 1};
    for (int i = 0; i < 8; i++)
      run_op(tf[i], ta[i], tb[i], texp[i], tlat[i], 1'b0);
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 50; i++) begin
      f = 3'($urandom);
      a = pick();
      b = pick();
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end
      run_op(f, a, b, ref_result(f, a, b), ref_latency(f, a, b), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 4; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = pick();
      run_op(f, a, b, ref_result(f, a, b), ref_latency(f, a, b), (i != 3));
    end
  endtask

  task automatic flush_case(input int at);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          seen;
    a = $urandom;
    b = $urandom;
    exp = ref_result(3'd0, a, b);
    funct3 = 3'd0;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    repeat (at) @(negedge clk);
    if (at == 34) begin
      checks++;
      if (done !== 1'b1 || result !== exp) begin
        errors++;
        $display("FAIL flush_with_done: done=%b result=%h required 1 %h", done, result, exp);
      end
      last_exp = exp;
    end
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== last_exp) begin
      errors++;
      $display("FAIL flush_at_%0d: busy=%b done=%b result=%h required 0 0 %h",
               at, busy, done, result, last_exp);
    end
    seen = 0;
    repeat (36) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_quiet_%0d: done/busy seen after flush, required none", at);
    end
    $display("FLUSH at=%0d a=%h b=%h result=%h", at, a, b, result);
  endtask

  task automatic test_flush();
    int points [4] = '{10, 1, 33, 34};
    for (int i = 0; i < 4; i++) flush_case(points[i]);
    funct3 = 3'd5;
    op_a   = 32'd5;
    op_b   = 32'd0;
    start  = 1'b1;
    flush  = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_block: busy=%b done=%b required 0 0", busy, done);
    end
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    run_op(3'd6, 32'd100, 32'd7, 32'd2, 34, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    funct3 = 3'd5;
    op_a   = $urandom;
    op_b   = $urandom | 32'h1;
    start  = 1'b1;
    @(posedge clk);
    #1;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h required 0 0 00000000",
               busy, done, result);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_exp = 32'h0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_quiet: done/busy seen after reset release, required none");
    end
    $display("RESET mid-DIVU result=%h", result);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'd0;
    op_a   = 32'h0;
    op_b   = 32'h0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
